// File: rtl/key_mapper_if.sv
// Keypad front-end bus: raw buttons and mode requests in, mapped key stream out.
interface key_mapper_if #(
  parameter int unsigned NUM_KEYS = 12
);
  logic [NUM_KEYS-1:0] btn_in;
  logic [1:0]          req_key_mode;
  logic                req_mode_change;
  logic [10:0]         key_mapped;
  logic                key_valid;
  logic                key_pressed;
  logic [1:0]          key_mode;

  modport master (
    output btn_in, req_key_mode, req_mode_change,
    input  key_mapped, key_valid, key_pressed, key_mode
  );

  modport slave (
    input  btn_in, req_key_mode, req_mode_change,
    output key_mapped, key_valid, key_pressed, key_mode
  );
endinterface

// File: rtl/key_mapper.sv
// Keypad synchroniser, debouncer and mode-dependent key code mapper.
// Optional auto-repeat in non-Morse modes: define KEY_MAPPER_AUTOREPEAT_EN.
module key_mapper #(
  parameter int unsigned NUM_KEYS      = 12,
  parameter int unsigned DEB_CYCLES    = 2000,
  parameter int unsigned REPEAT_DELAY  = 50000,
  parameter int unsigned REPEAT_PERIOD = 10000
) (
  input logic         clk,
  input logic         rst,
  key_mapper_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_KEYS);
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  if (NUM_KEYS < 2 || NUM_KEYS > 16 || DEB_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("key_mapper: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    act_idx_q, act_idx_d;
  logic [10:0]         mapped_q, mapped_d;
  logic                valid_q, valid_d, valid_nx;
  logic                pressed_q, pressed_d;
  logic [1:0]          mode_q, mode_d;
  logic [1:0]          pending_q, pending_d;
  logic [NUM_KEYS-1:0] sync_meta, btn_sync;
  logic [IDX_W-1:0]    low_idx;
  logic                act_btn;

  // Two-flop synchroniser on the raw buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      btn_sync  <= '0;
    end else begin
      sync_meta <= bus.btn_in;
      btn_sync  <= sync_meta;
    end
  end

  always_comb begin
    low_idx = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (btn_sync[i]) low_idx = IDX_W'(i);
    end
  end

  assign act_btn = btn_sync[act_idx_q];

  function automatic logic [10:0] map_key(input logic [1:0] mode, input logic [IDX_W-1:0] idx);
    logic [7:0] data;
    data    = 8'(idx);
    map_key = {3'b010, data};
    if (mode == 2'd0) begin
      if (idx == IDX_W'(0))      map_key = {3'b000, 8'd1};
      else if (idx == IDX_W'(1)) map_key = {3'b001, 8'd1};
    end else if (mode == 2'd1 && data < 8'd10) begin
      map_key = {3'b011, 8'h30 + data};
    end
  endfunction

  // Next-state and output decode; mode changes only take effect while idle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_idx_d = act_idx_q;
    mapped_d  = mapped_q;
    valid_d   = 1'b0;
    pressed_d = pressed_q;
    pending_d = bus.req_mode_change ? bus.req_key_mode : pending_q;
    mode_d    = mode_q;
    case (state_q)
      IDLE: begin
        mode_d = pending_d;
        if (|btn_sync) begin
          act_idx_d = low_idx;
          cnt_d     = '0;
          state_d   = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (!act_btn) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = HELD;
          mapped_d  = map_key(mode_q, act_idx_q);
          valid_d   = 1'b1;
          pressed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!act_btn) begin
          cnt_d   = '0;
          state_d = DEB_REL;
        end
      end
      DEB_REL: begin
        if (act_btn) begin
          state_d = HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          pressed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef KEY_MAPPER_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;
  logic             rpt_fire;

  // Repeat timer: runs while steadily held, frozen across a release bounce
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_fire    = 1'b0;
    if (state_q == HELD && state_d == HELD && mode_q != 2'd0) begin
      if (rpt_cnt_q == (rpt_first_q ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1))) begin
        rpt_fire    = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
      end
    end else if (state_q != DEB_REL || state_d == HELD) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end

  assign valid_nx = valid_d | rpt_fire;
`else
  assign valid_nx = valid_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      act_idx_q <= '0;
      mapped_q  <= '0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
      mode_q    <= 2'd0;
      pending_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_idx_q <= act_idx_d;
      mapped_q  <= mapped_d;
      valid_q   <= valid_nx;
      pressed_q <= pressed_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
    end
  end

  assign bus.key_mapped  = mapped_q;
  assign bus.key_valid   = valid_q;
  assign bus.key_pressed = pressed_q;
  assign bus.key_mode    = mode_q;
endmodule

// File: doc/key_mapper.md
Name: key_mapper

Overview:
- Front-end stage directly upstream of the Morse decode UI.
- Synchronises and debounces the raw keypad buttons and tracks one active key at a time.
- Translates the active key into an 11-bit code {key_type[2:0], key_data[7:0]} according to the current key mode.
- Produces the key_mapped / key_valid / key_pressed triple the decoder consumes, and accepts mode-change requests back from the decoder.

Parameters:
- NUM_KEYS, 12: number of raw buttons (2..16).
- DEB_CYCLES, 2000: debounce window in clk cycles (>=1); 20 ms at a 10 us clk.
- REPEAT_DELAY, 50000: cycles before the first auto-repeat (optional feature only).
- REPEAT_PERIOD, 10000: cycles between auto-repeats (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- btn_in  in  NUM_KEYS  raw asynchronous buttons, 1 = pressed
- req_key_mode  in  2  requested mode, from the decoder
- req_mode_change  in  1  one-cycle strobe that qualifies req_key_mode
- key_mapped  out  11  {key_type, key_data} of the active key
- key_valid  out  1  one-cycle pulse on a debounced press
- key_pressed  out  1  level, high while the debounced key is held
- key_mode  out  2  currently applied mode

Behaviour:
- Reset: key_mapped=0, key_valid=0, key_pressed=0, key_mode=0, pending mode=0, state=IDLE, counters=0.
- Input synchronisation: btn_in passes through 2 flops to give btn_sync.
- Key types: 000 DIT, 001 DAH, 010 CTRL, 011 NUM.
- Mode 0 (MORSE):
  - key0 -> {000, 8'd1}
  - key1 -> {001, 8'd1}
  - others -> {010, index}
- Mode 1 (NUMERIC):
  - keys 0..9 -> {011, 8'h30+index}
  - others -> {010, index}
- Mode 2 (CONTROL) and mode 3 (reserved, treated as mode 2): all keys -> {010, index}.
- IDLE:
  - If any btn_sync bit is high, capture the lowest set index into act_idx, clear the counter, go to DEB_PRESS.
  - Otherwise stay in IDLE.
- DEB_PRESS:
  - If btn_sync[act_idx]=0, go to IDLE. This is a glitch: no output changes.
  - Else increment the counter.
  - When the counter reaches DEB_CYCLES-1, go to HELD. In the same registered update: key_mapped = map(key_mode, act_idx), key_valid=1 for exactly one cycle, key_pressed=1.
- HELD:
  - Other keys are ignored.
  - If btn_sync[act_idx]=0, clear the counter and go to DEB_REL.
- DEB_REL:
  - If btn_sync[act_idx]=1 (bounce), return to HELD. key_pressed stays 1 and there is no new key_valid.
  - Else increment the counter.
  - At DEB_CYCLES-1, go to IDLE and set key_pressed=0.
- Latency:
  - Press: exactly DEB_CYCLES+2 clk edges from the first edge sampling btn_in high to key_valid/key_pressed high.
  - Release: exactly DEB_CYCLES+2 edges from the first edge sampling btn_in low to key_pressed low.
- key_mapped stays stable from the press until the next debounced press. It is never changed while key_pressed=1.
- Mode change:
  - req_mode_change latches req_key_mode into pending_mode.
  - pending_mode is copied to key_mode on any cycle the state is IDLE, so a strobe in IDLE is visible the next edge.
  - A strobe during DEB_PRESS/HELD/DEB_REL is deferred until IDLE. The mapping of an in-progress key never changes.
  - Of several strobes, the last one wins.
- Simultaneous keys: the lowest index wins at IDLE. Keys pressed while another is active are ignored until IDLE, then re-evaluated, with no extra wait.
- Reset mid-press: outputs return to their reset values on the next edge, even if the button is still held. After reset, a held button is treated as a new press and needs a full debounce.
- Counter width: $clog2(DEB_CYCLES+1); it never wraps past DEB_CYCLES-1.

Optional Feature:
- KEY_MAPPER_AUTOREPEAT_EN defined:
  - In HELD with key_mode != 0, a repeat counter runs.
  - key_valid pulses again after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles, with key_mapped unchanged.
  - The counter clears on leaving HELD and is frozen during DEB_REL; a bounce back to HELD restarts it from 0.
  - Mode 0 never repeats, so Morse durations are unaffected.
- Undefined: exactly one key_valid per debounced press in every mode; no repeat logic is synthesised.

Test Plan:
- DEB_CYCLES=4, mode 0, btn_in[0] held 20 cycles:
  - key_valid pulses once, 6 edges after the rise, with key_mapped=11'h001.
  - key_pressed stays high until 6 edges after the fall.
- Mode 0, btn_in[1] held, then btn_in[1] bounce of 2 cycles during release:
  - key_mapped=11'h101.
  - key_pressed does not drop during the bounce and there is no second key_valid.
- 3-cycle glitch on btn_in[5] with DEB_CYCLES=4: no key_valid, key_pressed stays 0, state back to IDLE.
- req_key_mode=1 strobed while key 0 is held:
  - key_mode stays 0 until release completes, then becomes 1.
  - A subsequent key 3 press gives key_mapped={011, 8'h33}.
- btn_in[2] and btn_in[7] rise on the same cycle in mode 2:
  - key_mapped={010, 8'd2}.
  - Key 7 is ignored until key 2 releases; then key_valid fires with {010, 8'd7} after DEB_CYCLES+2 edges.
- rst asserted while key_pressed=1 with the button still held:
  - All outputs are 0 on the next edge.
  - key_valid fires again DEB_CYCLES+2 edges after rst deasserts.
